// File: rtl/tdc_pulse_counter.sv
// Ring-oscillator pulse counter for the TDC: arms the oscillator, counts pulses until stop,
// and returns the captured count to the i_clk domain over a valid/ready handshake.
module tdc_pulse_counter #(
  parameter int COUNT_W       = 16,
  parameter int TIMEOUT       = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_nreset,
  input  logic               i_arm,
  input  logic               i_stop,
  input  logic               i_pulse,
  output logic               o_ring_nreset,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_overflow,
  output logic               o_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETTLE,
    CAPTURE,
    VALID
  } state_t;

  state_t             state;
  logic [TW-1:0]      tcnt;
  logic [SW-1:0]      scnt;
  logic               tflag;

  logic               pd_nrst;
  logic               stop_flag;
  logic [COUNT_W-1:0] cnt;
  logic               ovf;
  logic [1:0]         stop_sync;
  logic               stop_s;

  // o_busy is a registered copy of (state != IDLE), so it doubles as the glitch-free
  // pulse-domain clear: the counter and stop flag are held clear throughout IDLE.
  assign pd_nrst = i_nreset & o_busy;
  assign stop_s  = stop_sync[1];

  always_ff @(posedge i_stop or negedge pd_nrst) begin
    if (!pd_nrst) stop_flag <= 1'b0;
    else          stop_flag <= 1'b1;
  end

  always_ff @(posedge i_pulse or negedge pd_nrst) begin
    if (!pd_nrst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (!stop_flag) begin
      if (cnt == '1) ovf <= 1'b1;
      else           cnt <= cnt + 1'b1;
    end
  end

  // Flushed in IDLE so a stop from the previous run cannot leak into a fast re-arm.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset)          stop_sync <= '0;
    else if (state == IDLE) stop_sync <= '0;
    else                    stop_sync <= {stop_sync[0], stop_flag};
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state         <= IDLE;
      tcnt          <= '0;
      scnt          <= '0;
      tflag         <= 1'b0;
      o_ring_nreset <= 1'b0;
      o_busy        <= 1'b0;
      o_valid       <= 1'b0;
      o_count       <= '0;
      o_overflow    <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_arm) begin
            state         <= ARMED;
            tcnt          <= '0;
            tflag         <= 1'b0;
            o_ring_nreset <= 1'b1;
            o_busy        <= 1'b1;
          end
        end
        ARMED: begin
          if (stop_s) begin
            state         <= SETTLE;
            scnt          <= '0;
            o_ring_nreset <= 1'b0;
          end else if (tcnt == TCNT_LAST) begin
            state         <= SETTLE;
            scnt          <= '0;
            tflag         <= 1'b1;
            o_ring_nreset <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SETTLE: begin
          if (scnt == SCNT_LAST) state <= CAPTURE;
          else                   scnt  <= scnt + 1'b1;
        end
        CAPTURE: begin
          o_count    <= cnt;
          o_overflow <= ovf;
          o_timeout  <= tflag;
          o_valid    <= 1'b1;
          state      <= VALID;
        end
        VALID: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_pulse_counter.sv
// Randomized bench for tdc_pulse_counter: a wide default instance and a narrow, short-timeout
// instance share stimulus; results are predicted from the pulse/stop sequence each run drives.
`timescale 1ns/1ps
module tb_tdc_pulse_counter;

  localparam int SETTLE = 4;
  localparam int A_W = 16, A_TO = 1024;
  localparam int B_W = 4,  B_TO = 64;

  logic clk = 1'b0, nreset = 1'b0, arm = 1'b0, stop = 1'b0, pulse = 1'b0, ready = 1'b0;
  logic a_ring, a_busy, a_valid, a_ovf, a_tmo;
  logic b_ring, b_busy, b_valid, b_ovf, b_tmo;
  logic [A_W-1:0] a_count;
  logic [B_W-1:0] b_count;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  tdc_pulse_counter #(.COUNT_W(A_W), .TIMEOUT(A_TO), .SETTLE_CYCLES(SETTLE)) dut_a (
    .i_clk(clk), .i_nreset(nreset), .i_arm(arm), .i_stop(stop), .i_pulse(pulse),
    .o_ring_nreset(a_ring), .o_busy(a_busy), .o_valid(a_valid), .i_ready(ready),
    .o_count(a_count), .o_overflow(a_ovf), .o_timeout(a_tmo));

  tdc_pulse_counter #(.COUNT_W(B_W), .TIMEOUT(B_TO), .SETTLE_CYCLES(SETTLE)) dut_b (
    .i_clk(clk), .i_nreset(nreset), .i_arm(arm), .i_stop(stop), .i_pulse(pulse),
    .o_ring_nreset(b_ring), .o_busy(b_busy), .o_valid(b_valid), .i_ready(ready),
    .o_count(b_count), .o_overflow(b_ovf), .o_timeout(b_tmo));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat(input int k, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (k > mx) ? mx : longint'(k);
  endfunction

  task automatic check_reset_outs();
    check("a_rst_ring", a_ring, 0);  check("a_rst_busy", a_busy, 0);
    check("a_rst_valid", a_valid, 0); check("a_rst_count", a_count, 0);
    check("a_rst_ovf", a_ovf, 0);    check("a_rst_tmo", a_tmo, 0);
    check("b_rst_ring", b_ring, 0);  check("b_rst_busy", b_busy, 0);
    check("b_rst_valid", b_valid, 0); check("b_rst_count", b_count, 0);
    check("b_rst_ovf", b_ovf, 0);    check("b_rst_tmo", b_tmo, 0);
  endtask

  task automatic one_pulse();
    #($urandom_range(1, 3)) pulse = 1'b1;
    #($urandom_range(1, 3)) pulse = 1'b0;
  endtask

  // Raise stop away from the clock edge so the cycle it lands in is unambiguous.
  task automatic raise_stop(output int at_cyc, input int cyc_now);
    while ((($time % 10) >= 4) && (($time % 10) <= 6)) #1;
    stop   = 1'b1;
    at_cyc = cyc_now;
  endtask

  // stop_at: pulse index before which stop rises (np = after all pulses, -1 = never).
  task automatic run_meas(input int np, input int stop_at, input int n_extra, input bit pre_stop,
                          input bit rearm, input int rdy_wait, input bit rdy_early);
    int  k, cyc, stop_cyc, va_cyc, vb_cyc, ra, rb, extras, w;
    bit  va, vb, tmo_exp;
    logic [63:0] ca, cb, oa, ob, ta, tb;
    cyc = 0; stop_cyc = 0; va_cyc = 0; vb_cyc = 0; va = 0; vb = 0; extras = n_extra;
    k       = (stop_at < 0) ? np : ((stop_at < np) ? stop_at : np);
    tmo_exp = (stop_at < 0);

    w = 0;
    while ((a_busy || b_busy) && w < 3000) begin @(negedge clk); w++; end
    check("idle_before_arm", {a_busy, b_busy}, 0);

    @(negedge clk); stop = 1'b0; ready = 1'b0;
    @(negedge clk); stop = pre_stop; arm = 1'b1;
    @(negedge clk); arm = 1'b0; ready = rdy_early;
    check("a_ring_armed", a_ring, 1);
    check("b_ring_armed", b_ring, 1);
    ra = 1; rb = 1;

    fork
      begin
        for (int i = 0; i < np; i++) begin
          if (i == stop_at) raise_stop(stop_cyc, cyc);
          if (stop_at >= 0 && i > stop_at && ((i - stop_at) % 3) == 0 && extras > 0) begin
            stop = 1'b0; #1 stop = 1'b1; extras--;
          end
          one_pulse();
        end
        if (stop_at >= np) raise_stop(stop_cyc, cyc);
        if (rearm) begin
          @(negedge clk); arm = 1'b1;
          @(negedge clk); arm = 1'b0;
        end
      end
      begin
        while (!(va && vb) && cyc < 3000) begin
          @(posedge clk); #1; cyc++;
          if (a_ring) ra++;
          if (b_ring) rb++;
          if (a_valid && !va) begin va = 1; va_cyc = cyc; ca = a_count; oa = a_ovf; ta = a_tmo; end
          if (b_valid && !vb) begin vb = 1; vb_cyc = cyc; cb = b_count; ob = b_ovf; tb = b_tmo; end
        end
      end
    join

    check("a_valid_seen", va, 1);
    check("b_valid_seen", vb, 1);
    if (va) begin
      check("a_count", ca, sat(k, A_W));
      check("a_ovf", oa, (longint'(k) > sat(k, A_W)));
      check("a_tmo", ta, tmo_exp);
    end
    if (vb) begin
      check("b_count", cb, sat(k, B_W));
      check("b_ovf", ob, (longint'(k) > sat(k, B_W)));
      check("b_tmo", tb, tmo_exp);
    end
    if (tmo_exp) begin
      check("a_armed_cycles", ra, A_TO);
      check("b_armed_cycles", rb, B_TO);
    end else begin
      check("a_latency_ok", (va_cyc - stop_cyc >= SETTLE + 4) && (va_cyc - stop_cyc <= SETTLE + 5), 1);
      check("b_latency_ok", (vb_cyc - stop_cyc >= SETTLE + 4) && (vb_cyc - stop_cyc <= SETTLE + 5), 1);
    end

    if (!rdy_early) begin
      check("a_ring_killed", a_ring, 0);
      check("b_ring_killed", b_ring, 0);
      for (int c = 0; c < rdy_wait; c++) begin
        @(negedge clk);
        check("a_hold_valid", a_valid, 1);
        check("b_hold_valid", b_valid, 1);
        check("a_hold_count", a_count, sat(k, A_W));
        check("b_hold_count", b_count, sat(k, B_W));
      end
      @(negedge clk); ready = 1'b1;
      @(negedge clk); ready = 1'b0;
    end else begin
      w = 0;
      while ((a_busy || b_busy) && w < 3000) begin @(negedge clk); w++; end
      ready = 1'b0;
    end
    check("a_busy_done", a_busy, 0);
    check("b_busy_done", b_busy, 0);
    check("a_valid_done", a_valid, 0);
    check("b_valid_done", b_valid, 0);
    check("a_count_kept", a_count, sat(k, A_W));
    check("b_count_kept", b_count, sat(k, B_W));
    check("b_tmo_kept", b_tmo, tmo_exp);
  endtask

  initial begin
    int np, sa;
    #1 check_reset_outs();
    #20; @(negedge clk); nreset = 1'b1;

    run_meas(37, 37, 0, 0, 0, 1, 0);
    run_meas(20, 20, 0, 0, 0, 2, 0);
    run_meas(10, -1, 0, 0, 0, 1, 0);
    run_meas(14, 5, 2, 0, 0, 10, 0);
    run_meas(5, 0, 0, 0, 0, 0, 0);
    run_meas(6, -1, 0, 0, 1, 1, 0);
    run_meas(8, -1, 0, 1, 0, 1, 0);
    run_meas(12, 12, 0, 0, 0, 0, 1);

    @(negedge clk); stop = 1'b0; arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    for (int i = 0; i < 9; i++) one_pulse();
    #3 nreset = 1'b0;
    #1 check_reset_outs();
    @(negedge clk); nreset = 1'b1;
    run_meas(6, 6, 0, 0, 0, 1, 0);

    for (int r = 0; r < 20; r++) begin
      np = int'($urandom_range(0, 40));
      sa = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, np));
      run_meas(np, sa, int'($urandom_range(0, 2)), 0, ($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
